// File: rtl/mouse_scaler.sv
// ---------------------------------------------------------------------------
// mouse_scaler
//
// Converts raw 12-bit mouse-controller coordinates into the 7-bit OLED cursor
// position used by the pixel-colour stage. Each axis is divided by its own
// divisor on one shared serial restoring divider (one quotient bit per cycle,
// x first, then y). The quotient is clamped to the panel size. New positions
// are committed only on a frame boundary so the cursor never tears mid-frame.
// A separate, FSM-independent path synchronises the left mouse button and
// emits a single-cycle pulse on each press.
//
// Parameters:
//   DIV_X, DIV_Y  raw units per OLED column / row (1..4095)
//   MAX_X, MAX_Y  clamp ceilings for the committed column / row
//
// Ports:
//   clock          system clock, rising edge
//   reset          synchronous, active-high reset
//   mouse_x/y      raw position, valid while mouse_event is high
//   mouse_event    one-cycle strobe from the mouse controller
//   mouse_left     raw left-button level (asynchronous to clock)
//   frame_begin    one-cycle strobe at display pixel index 0
//   mouse_x_scale  committed cursor column
//   mouse_y_scale  committed cursor row
//   click_pulse    one-cycle pulse per left-button press
//   busy           high whenever a conversion is in flight or awaiting commit
// ---------------------------------------------------------------------------
module mouse_scaler #(
    parameter int unsigned DIV_X = 10,
    parameter int unsigned DIV_Y = 10,
    parameter int unsigned MAX_X = 95,
    parameter int unsigned MAX_Y = 63
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] mouse_x,
    input  logic [11:0] mouse_y,
    input  logic        mouse_event,
    input  logic        mouse_left,
    input  logic        frame_begin,
    output logic [6:0]  mouse_x_scale,
    output logic [6:0]  mouse_y_scale,
    output logic        click_pulse,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        DIVX,
        DIVY,
        HOLD
    } state_t;

    localparam logic [12:0] DIV_X_W = 13'(DIV_X);
    localparam logic [12:0] DIV_Y_W = 13'(DIV_Y);
    localparam logic [11:0] MAX_X_W = 12'(MAX_X);
    localparam logic [11:0] MAX_Y_W = 12'(MAX_Y);
    localparam logic [3:0]  LAST_ITER = 4'd11;

    state_t      state_q,   state_d;
    logic        pending_q, pending_d;
    logic [11:0] shadow_x_q, shadow_x_d;
    logic [11:0] shadow_y_q, shadow_y_d;
    // The working registers double as the dividend shift registers: the
    // quotient bits shift in from the right as the dividend bits shift out,
    // so after 12 iterations each one holds its axis quotient.
    logic [11:0] work_x_q,  work_x_d;
    logic [11:0] work_y_q,  work_y_d;
    // The stored remainder is always below the divisor, so 12 bits suffice;
    // the 13th bit only exists transiently in the shifted value.
    logic [11:0] rem_q,     rem_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic [6:0]  x_out_q,   x_out_d;
    logic [6:0]  y_out_q,   y_out_d;

    logic        sync1_q, sync2_q, hist_q;
    logic        click_q, click_d;

    // Divider datapath signals
    logic [11:0] div_cur;
    logic [12:0] divisor;
    logic [12:0] rem_shift;
    logic        rem_ge;
    logic [11:0] rem_next;
    logic [11:0] cur_next;

    // One restoring-division step on whichever axis is active.
    always_comb begin
        div_cur   = (state_q == DIVY) ? work_y_q : work_x_q;
        divisor   = (state_q == DIVY) ? DIV_Y_W  : DIV_X_W;
        rem_shift = {rem_q, div_cur[11]};
        rem_ge    = (rem_shift >= divisor);
        rem_next  = rem_ge ? 12'(rem_shift - divisor) : rem_shift[11:0];
        cur_next  = {div_cur[10:0], rem_ge};
    end

    // Shadow capture, pending flag and conversion FSM next-state logic.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        shadow_x_d = shadow_x_q;
        shadow_y_d = shadow_y_q;
        work_x_d   = work_x_q;
        work_y_d   = work_y_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        x_out_d    = x_out_q;
        y_out_d    = y_out_q;

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    work_x_d  = shadow_x_q;
                    work_y_d  = shadow_y_q;
                    rem_d     = 12'd0;
                    cnt_d     = 4'd0;
                    pending_d = 1'b0;
                    state_d   = DIVX;
                end
            end
            DIVX: begin
                work_x_d = cur_next;
                rem_d    = rem_next;
                cnt_d    = 4'(cnt_q + 4'd1);
                if (cnt_q == LAST_ITER) begin
                    // Fresh remainder and counter for the y axis.
                    rem_d   = 12'd0;
                    cnt_d   = 4'd0;
                    state_d = DIVY;
                end
            end
            DIVY: begin
                work_y_d = cur_next;
                rem_d    = rem_next;
                cnt_d    = 4'(cnt_q + 4'd1);
                if (cnt_q == LAST_ITER) begin
                    cnt_d   = 4'd0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (frame_begin) begin
                    x_out_d = (work_x_q > MAX_X_W) ? MAX_X_W[6:0] : work_x_q[6:0];
                    y_out_d = (work_y_q > MAX_Y_W) ? MAX_Y_W[6:0] : work_y_q[6:0];
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new event always wins over the IDLE clear of the flag, so an
        // event arriving on the load cycle queues another conversion.
        if (mouse_event) begin
            shadow_x_d = mouse_x;
            shadow_y_d = mouse_y;
            pending_d  = 1'b1;
        end
    end

    // Conversion state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            shadow_x_q <= 12'd0;
            shadow_y_q <= 12'd0;
            work_x_q   <= 12'd0;
            work_y_q   <= 12'd0;
            rem_q      <= 12'd0;
            cnt_q      <= 4'd0;
            x_out_q    <= 7'd0;
            y_out_q    <= 7'd0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            shadow_x_q <= shadow_x_d;
            shadow_y_q <= shadow_y_d;
            work_x_q   <= work_x_d;
            work_y_q   <= work_y_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            x_out_q    <= x_out_d;
            y_out_q    <= y_out_d;
        end
    end

    // Rising-edge detect on the synchronised button level.
    always_comb begin
        click_d = sync2_q & ~hist_q;
    end

    // Two-flop synchroniser, history flop and registered click pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
            click_q <= 1'b0;
        end else begin
            sync1_q <= mouse_left;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            click_q <= click_d;
        end
    end

    assign mouse_x_scale = x_out_q;
    assign mouse_y_scale = y_out_q;
    assign click_pulse   = click_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mouse_scaler.sv
// ---------------------------------------------------------------------------
// tb_mouse_scaler
//
// Directed bench for mouse_scaler with default parameters (divisors 10,
// clamps 95/63). Inputs are driven 1 ns after each rising edge and outputs
// are sampled at the same point, so every value seen is settled.
// ---------------------------------------------------------------------------
module tb_mouse_scaler;

    logic        clock;
    logic        reset;
    logic [11:0] mouse_x;
    logic [11:0] mouse_y;
    logic        mouse_event;
    logic        mouse_left;
    logic        frame_begin;
    logic [6:0]  mouse_x_scale;
    logic [6:0]  mouse_y_scale;
    logic        click_pulse;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    mouse_scaler dut (
        .clock         (clock),
        .reset         (reset),
        .mouse_x       (mouse_x),
        .mouse_y       (mouse_y),
        .mouse_event   (mouse_event),
        .mouse_left    (mouse_left),
        .frame_begin   (frame_begin),
        .mouse_x_scale (mouse_x_scale),
        .mouse_y_scale (mouse_y_scale),
        .click_pulse   (click_pulse),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance n rising edges and settle just after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input int observed, input int expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_pos(input string tag, input int ex, input int ey, input int eb);
        check_output({tag, "_x"}, int'(mouse_x_scale), ex);
        check_output({tag, "_y"}, int'(mouse_y_scale), ey);
        check_output({tag, "_busy"}, int'(busy), eb);
    endtask

    // Present one event; it is sampled at the next edge.
    task automatic apply_event(input logic [11:0] x, input logic [11:0] y);
        mouse_x     = x;
        mouse_y     = y;
        mouse_event = 1'b1;
        tick(1);
        mouse_event = 1'b0;
    endtask

    task automatic apply_frame();
        frame_begin = 1'b1;
        tick(1);
        frame_begin = 1'b0;
    endtask

    // Raise the button, watch 50 edges, and report where pulses appeared.
    task automatic press_button(output int pulses, output int first_at);
        pulses   = 0;
        first_at = -1;
        mouse_left = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            tick(1);
            if (click_pulse === 1'b1) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
        end
        mouse_left = 1'b0;
    endtask

    initial begin
        int pulses;
        int first_at;

        reset       = 1'b1;
        mouse_x     = 12'd0;
        mouse_y     = 12'd0;
        mouse_event = 1'b0;
        mouse_left  = 1'b0;
        frame_begin = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);

        // Reset state
        check_pos("reset", 0, 0, 0);
        check_output("reset_click", int'(click_pulse), 0);

        // Basic conversion: 500/10=50, 300/10=30
        apply_event(12'd500, 12'd300);
        tick(1);
        check_output("basic_busy_e1", int'(busy), 1);
        tick(37);
        check_pos("basic_pre_frame", 0, 0, 1);
        apply_frame();
        check_pos("basic_commit", 50, 30, 0);

        // Clamp at minimum latency; frame_begin on the HOLD-entry edge is ignored
        apply_event(12'd1200, 12'd4095);
        tick(24);
        apply_frame();
        check_pos("hold_entry_frame", 50, 30, 1);
        apply_frame();
        check_pos("clamp_commit", 95, 63, 0);

        apply_event(12'd9, 12'd0);
        tick(40);
        apply_frame();
        check_pos("small_commit", 0, 0, 0);

        // Frame gating: 250/10=25, 130/10=13
        apply_event(12'd250, 12'd130);
        tick(500);
        check_pos("gate_wait", 0, 0, 1);
        apply_frame();
        check_pos("gate_commit", 25, 13, 0);
        tick(40);
        apply_frame();
        check_pos("gate_no_repeat", 25, 13, 0);

        // Event collision: only first and latest are converted
        apply_event(12'd100, 12'd100);
        tick(4);
        apply_event(12'd200, 12'd200);
        tick(2);
        apply_event(12'd300, 12'd300);
        tick(32);
        apply_frame();
        check_pos("collide_first", 10, 10, 0);
        tick(1);
        check_output("collide_restart_busy", int'(busy), 1);
        tick(30);
        apply_frame();
        check_pos("collide_second", 30, 30, 0);
        tick(40);
        apply_frame();
        check_pos("collide_no_third", 30, 30, 0);

        // Reset in the middle of a conversion of (700,400)
        apply_event(12'd700, 12'd400);
        tick(14);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_pos("midreset", 0, 0, 0);
        tick(30);
        apply_frame();
        tick(5);
        apply_frame();
        check_pos("midreset_no_commit", 0, 0, 0);

        // Click path: two presses, one pulse each, 3 edges after the rise
        press_button(pulses, first_at);
        check_output("click1_count", pulses, 1);
        check_output("click1_delay", first_at, 3);
        tick(10);
        check_output("click_release", int'(click_pulse), 0);
        press_button(pulses, first_at);
        check_output("click2_count", pulses, 1);
        check_output("click2_delay", first_at, 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time guard so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time budget");
        $fatal(1, "[TB] timeout");
    end

endmodule
